snitch_icache_perf_counters: RTL and testbench

SNITCH_ICACHE_PERF_COUNTERS -- requirements
Module: snitch_icache_perf_counters

---
 rtl/snitch_icache_perf_counters.sv | 126 ++++++++++++
 tb/tb_snitch_icache_perf_counters.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_perf_counters.sv
// Instruction-cache performance counters: 11 saturating event counters with sticky
// overflow flags, read through a simple req/gnt, rvalid/rready port.
module snitch_icache_perf_counters #(
  parameter int unsigned NR_FETCH_PORTS = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_FETCH_PORTS-1:0][4:0] l0_events_i,
  input  logic [5:0]                     l1_events_i,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic                           req_i,
  input  logic [3:0]                     addr_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [31:0]                    rdata_o
);

  localparam int unsigned NumL0  = 5;
  localparam int unsigned NumL1  = 6;
  localparam int unsigned NumCnt = NumL0 + NumL1;
  localparam int unsigned SumW   = CNT_WIDTH + 4;

  typedef enum logic {StIdle, StResp} state_e;

  logic [NumCnt-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NumCnt-1:0]                ovf_q, ovf_d;
  logic [NumCnt-1:0][SumW-1:0]      incr, sum;
  logic [31:0]                      rd_val;
  logic [31:0]                      rdata_q, rdata_d;
  state_e                           state_q, state_d;

  // L0 fields count how many fetch ports raised them; L1 fields count once.
  always_comb begin
    incr = '0;
    for (int f = 0; f < NumL0; f++) begin
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        incr[f] = incr[f] + SumW'(l0_events_i[p][f]);
      end
    end
    for (int f = 0; f < NumL1; f++) begin
      incr[NumL0+f] = SumW'(l1_events_i[f]);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sum   = '0;
    for (int i = 0; i < NumCnt; i++) begin
      sum[i] = SumW'(cnt_q[i]) + incr[i];
    end
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = '0;
    end else if (enable_i) begin
      for (int i = 0; i < NumCnt; i++) begin
        if (|sum[i][SumW-1:CNT_WIDTH]) begin
          cnt_d[i] = '1;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[i][CNT_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumCnt; i++) begin
      if (addr_i == 4'(i)) rd_val[CNT_WIDTH-1:0] = cnt_q[i];
    end
    if (addr_i == 4'd11) rd_val = {21'b0, ovf_q};
  end

  // rdata_q is kept at zero whenever no response is pending.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    gnt_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          state_d = StResp;
          rdata_d = rd_val;
        end
      end
      StResp: begin
        gnt_o = req_i && rready_i;
        if (rready_i) begin
          if (req_i) begin
            rdata_d = rd_val;
          end else begin
            state_d = StIdle;
            rdata_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        rdata_d = '0;
      end
    endcase
  end

  assign rvalid_o = (state_q == StResp);
  assign rdata_o  = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ovf_q   <= '0;
      rdata_q <= '0;
      state_q <= StIdle;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Bench for snitch_icache_perf_counters: directed scenarios plus random event traffic,
// checked against a saturating-arithmetic reference model.
module tb_snitch_icache_perf_counters;

  localparam int unsigned NP   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NP-1:0][4:0] l0_ev = '0;
  logic [5:0]         l1_ev = '0;
  logic               en = 1'b0;
  logic               clr = 1'b0;
  logic               req = 1'b0;
  logic [3:0]         addr = '0;
  logic               rready = 1'b1;
  logic               gnt, rvalid;
  logic [31:0]        rdata;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_cnt[11];
  bit          m_ovf[11];

  snitch_icache_perf_counters #(
    .NR_FETCH_PORTS(NP),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .l0_events_i(l0_ev),
    .l1_events_i(l1_ev),
    .enable_i   (en),
    .clear_i    (clr),
    .req_i      (req),
    .addr_i     (addr),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rready_i   (rready),
    .rdata_o    (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_zero();
    for (int i = 0; i < 11; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_add(input int i, input int unsigned n);
    int unsigned s;
    s = m_cnt[i] + n;
    if (s > CMAX) begin
      m_cnt[i] = CMAX;
      m_ovf[i] = 1'b1;
    end else begin
      m_cnt[i] = s;
    end
  endfunction

  function automatic void model_step();
    int unsigned n;
    if (rst || clr) begin
      model_zero();
    end else if (en) begin
      for (int f = 0; f < 5; f++) begin
        n = 0;
        for (int p = 0; p < NP; p++) n += l0_ev[p][f] ? 1 : 0;
        model_add(f, n);
      end
      for (int f = 0; f < 6; f++) model_add(5 + f, l1_ev[f] ? 1 : 0);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (a < 4'd11) v = m_cnt[a];
    else if (a == 4'd11) for (int i = 0; i < 11; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_events(input int unsigned odds);
    for (int p = 0; p < NP; p++)
      for (int f = 0; f < 5; f++) l0_ev[p][f] = ($urandom_range(0, odds) == 0);
    for (int f = 0; f < 6; f++) l1_ev[f] = ($urandom_range(0, odds) == 0);
  endtask

  // Single read from idle: grant this cycle, response on the next.
  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    req = 1'b1; addr = a; rready = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'd1);
    check({tag, "_rvalid_lo"}, 32'(rvalid), 32'd0);
    tick();
    req = 1'b0;
    #1;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    tick();
  endtask

  logic [31:0] e0, e1, e2, exp_s;
  logic [31:0] snap[5];

  initial begin
    model_zero();
    #3;
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_gnt", 32'(gnt), 32'd0);
    tick(); tick();
    #3 rst = 1'b0;
    en = 1'b1;

    // Three of four ports report an L0 hit for 10 cycles.
    l0_ev = '0;
    for (int p = 0; p < 3; p++) l0_ev[p][1] = 1'b1;
    repeat (10) tick();
    l0_ev = '0;
    read_check("l0_hit_30", 4'd1, 32'd30);

    // L1 miss saturates the 8-bit counter and raises its overflow flag.
    l1_ev = 6'b000001;
    repeat (300) tick();
    l1_ev = '0;
    read_check("l1_miss_sat", 4'd5, 32'd255);
    read_check("ovf_flags", 4'd11, 32'h20);
    read_check("ovf_model", 4'd11, model_read(4'd11));

    // Clear wins over a same-cycle event.
    l1_ev = 6'b000010;
    repeat (7) tick();
    l1_ev = '0;
    read_check("l1_hit_7", 4'd6, 32'd7);
    clr = 1'b1; l1_ev = 6'b000010;
    tick();
    clr = 1'b0; l1_ev = '0;
    read_check("clear_cnt", 4'd6, 32'd0);
    read_check("clear_ovf", 4'd11, 32'd0);

    // Random traffic with occasional reads, disables and clears.
    for (int k = 0; k < 120; k++) begin
      rand_events(5);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0) begin
        addr = 4'($urandom_range(0, 15));
        read_check("rand_read", addr, model_read(addr));
      end else begin
        tick();
      end
    end
    clr = 1'b0; en = 1'b1;

    // Stalled response stays stable while events keep arriving.
    rand_events(3);
    req = 1'b1; addr = 4'd4; rready = 1'b1;
    #1;
    exp_s = model_read(4'd4);
    check("stall_gnt", 32'(gnt), 32'd1);
    tick();
    rready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_events(3);
      #1;
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rdata", rdata, exp_s);
      check("stall_gnt_lo", 32'(gnt), 32'd0);
      tick();
    end
    rready = 1'b1; req = 1'b0;
    #1;
    check("stall_release", rdata, exp_s);
    tick();
    check("stall_done", 32'(rvalid), 32'd0);

    // Back-to-back reads of indices 0, 1, 2.
    rand_events(4);
    req = 1'b1; addr = 4'd0;
    #1;
    e0 = model_read(4'd0);
    check("b2b_gnt0", 32'(gnt), 32'd1);
    tick();
    addr = 4'd1;
    #1;
    check("b2b_rvalid0", 32'(rvalid), 32'd1);
    check("b2b_rdata0", rdata, e0);
    check("b2b_gnt1", 32'(gnt), 32'd1);
    e1 = model_read(4'd1);
    tick();
    addr = 4'd2;
    #1;
    check("b2b_rvalid1", 32'(rvalid), 32'd1);
    check("b2b_rdata1", rdata, e1);
    e2 = model_read(4'd2);
    tick();
    req = 1'b0;
    #1;
    check("b2b_rvalid2", 32'(rvalid), 32'd1);
    check("b2b_rdata2", rdata, e2);
    tick();
    check("b2b_idle_rvalid", 32'(rvalid), 32'd0);
    check("b2b_idle_rdata", rdata, 32'd0);

    // Disabled window drops every event.
    l0_ev = '0; l1_ev = '0;
    for (int i = 0; i < 5; i++) snap[i] = model_read(4'(i));
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_events(1);
      tick();
    end
    l0_ev = '0; l1_ev = '0;
    for (int i = 0; i < 5; i++) read_check("frozen", 4'(i), snap[i]);
    en = 1'b1;

    // Asynchronous reset during a pending response.
    rand_events(3);
    repeat (4) tick();
    req = 1'b1; addr = 4'd1;
    tick();
    req = 1'b0;
    #1;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    model_zero();
    l0_ev = '0; l1_ev = '0;
    tick();
    #2 rst = 1'b0;
    tick();
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    read_check("post_rst_r0", 4'd0, 32'd0);
    read_check("post_rst_r1", 4'd1, 32'd0);
    read_check("post_rst_r11", 4'd11, 32'd0);

    // Counting restarts on the first enabled edge.
    l1_ev = 6'b000100;
    tick();
    l1_ev = '0;
    read_check("first_count", 4'd7, 32'd1);
    read_check("unused_idx", 4'd13, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
